program_loader: RTL and testbench
=================================

# program_loader

Boot-time sequencer for the UART program download. It runs the host handshake: sends 0x99, receives a 32-bit byte count, then assembles that many bytes into 32-bit words and writes them into program memory. It finishes by sending 0xAA and asserting `load_done`, which holds the pipeline in reset until the program is in place. It sits between the byte-level UART receiver/transmitter and the program memory write port, under the top-level CPU.

## Interface
- `PROGRAM_MEMORY_ADDRESS_BITWIDTH`, default 12: word-address width of program memory. Depth is 2^width words.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rx_valid`  in  1: one-cycle pulse when a received byte is present on `rx_data`. There is no backpressure.
- `rx_data`  in  8: received byte.
- `tx_ready`  in  1: transmitter can accept a byte.
- `tx_valid`  out  1: byte on `tx_data` is offered.
- `tx_data`  out  8: byte to transmit.
- `program_memory_write_enable`  out  1: one-cycle word write strobe.
- `program_memory_write_address`  out  PROGRAM_MEMORY_ADDRESS_BITWIDTH: word address.
- `program_memory_write_data`  out  32: assembled word.
- `load_done`  out  1: download finished. Stays high until reset.
- `overflow`  out  1: byte count exceeded memory depth. Sticky until reset.

## Operation
- **States:**
  - SEND_99: `tx_valid`=1, `tx_data`=0x99. Go to RECV_SIZE on `tx_valid & tx_ready`.
  - RECV_SIZE: collect 4 bytes, little-endian (first byte = bits 7:0), into a 32-bit `size`. After the 4th byte, go to SEND_AA if `size`==0, else to RECV_DATA.
  - RECV_DATA: collect bytes into a word shift register, little-endian.
    - A word is complete on every 4th byte, or on the final byte of the count.
    - On completion, write the word at `addr`, then increment `addr`.
    - Unfilled upper bytes of a final partial word are zero.
    - Go to SEND_AA in the cycle after the final byte's write.
  - SEND_AA: `tx_valid`=1, `tx_data`=0xAA. Go to DONE on handshake.
  - DONE: `load_done`=1. All `rx_valid` pulses are ignored. The state is absorbing.
- **Byte counter:** 32-bit `remaining`, loaded with `size` and decremented per received data byte. The final byte is the one received when `remaining`==1.
- **Word count** = ceil(`size`/4).
- **Capacity:** words whose index is ≥ 2^PROGRAM_MEMORY_ADDRESS_BITWIDTH are not written.
  - Their bytes are still consumed and counted.
  - `overflow` is set on the first such word.
  - `addr` saturates at its maximum value and does not wrap.
- **Ignored input:** `rx_valid` in SEND_99, SEND_AA and DONE is dropped; no buffering.
- **`tx_ready` low:** `tx_valid`/`tx_data` hold steady until the handshake.

## Timing
- **Reset values:**
  - State = SEND_99.
  - `tx_valid`=1 and `tx_data`=0x99 (combinational from state).
  - `program_memory_write_enable`=0, address=0, data=0.
  - `load_done`=0, `overflow`=0.
  - `size`, `remaining` and the byte index are cleared.
- **Write latency:** `program_memory_write_enable` is registered. It pulses in the cycle after the `rx_valid` that completes a word, with address and data stable in that cycle.
- **Back-to-back input:** `rx_valid` on consecutive cycles must be accepted; one byte per cycle is sustained.
- **State change timing:** state changes on the clock edge after the qualifying handshake or byte.
- **Completion latency:** `tx_valid` for 0xAA rises 2 cycles after the final data `rx_valid`. `load_done` rises the cycle after the 0xAA handshake.
- **Zero size:** with `size`==0, SEND_AA is entered the cycle after the 4th size byte. No memory write occurs.
- **Reset mid-load:** returns to SEND_99 immediately. Partially written memory contents are not cleared. `load_done` drops asynchronously.

## Structure
- **Shared package:**
  - The state enum `program_loader_state_t`.
  - Constants `BOOT_START_BYTE` = 8'h99 and `BOOT_END_BYTE` = 8'hAA.
  - The program memory address width shared with the program memory module.
- **Sub-module:** one, `byte_word_assembler`. It covers the 4-byte little-endian shift register with byte index, a word-complete flag and a flush-on-last input, and is reused for the size field and for data words.

## Test plan
- **Basic load:**
  - Stimulus: reset with `tx_ready`=1; expect 0x99 handshake. Then size bytes 08 00 00 00 followed by 01 02 03 04 05 06 07 08.
  - Required response: writes (0, 0x04030201) then (1, 0x08070605); 0xAA sent; `load_done`=1; `overflow`=0.
- **Partial final word:**
  - Stimulus: size 5, data AA BB CC DD EE.
  - Required response: writes (0, 0xDDCCBBAA) then (1, 0x000000EE); then 0xAA.
- **Zero size:**
  - Stimulus: size 00 00 00 00.
  - Required response: no write strobe; 0xAA sent; `load_done`=1.
- **Overflow:**
  - Stimulus: PROGRAM_MEMORY_ADDRESS_BITWIDTH=2; size 20 bytes.
  - Required response: exactly 4 writes at addresses 0..3; `overflow`=1 at the 5th word; all bytes consumed; 0xAA sent.
- **Backpressure and stray input:**
  - Stimulus: hold `tx_ready`=0 for 10 cycles while sending `rx_valid` pulses.
  - Required response: `tx_data` stays 0x99; the pulses are ignored. After release, a size load proceeds normally.
- **Reset mid-load:**
  - Stimulus: assert `reset_n`=0 after 3 data bytes.
  - Required response: outputs return to reset values asynchronously; the protocol restarts with 0x99.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program download sequencer.
// The program memory module imports the same address width default.
package program_loader_pkg;

    typedef enum logic [2:0] {
        SEND_99,
        RECV_SIZE,
        RECV_DATA,
        SEND_AA,
        DONE
    } program_loader_state_t;

    localparam logic [7:0] BOOT_START_BYTE = 8'h99;
    localparam logic [7:0] BOOT_END_BYTE   = 8'hAA;

    localparam int DEFAULT_PROGRAM_MEMORY_ADDRESS_BITWIDTH = 12;

endpackage

// File: rtl/program_loader_if.sv
// UART byte handshake plus program memory write port seen by the loader.
// The loader drives through the master modport; the environment uses slave.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = DEFAULT_PROGRAM_MEMORY_ADDRESS_BITWIDTH
);
    logic                        rx_valid;
    logic [7:0]                  rx_data;
    logic                        tx_ready;
    logic                        tx_valid;
    logic [7:0]                  tx_data;
    logic                        program_memory_write_enable;
    logic [ADDRESS_BITWIDTH-1:0] program_memory_write_address;
    logic [31:0]                 program_memory_write_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data,
        output program_memory_write_enable,
        output program_memory_write_address,
        output program_memory_write_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data,
        input  program_memory_write_enable,
        input  program_memory_write_address,
        input  program_memory_write_data
    );

endinterface

// File: rtl/program_loader_assembler.sv
// Little-endian byte-to-word assembler shared by the size field and data words.
// The completed word (including the byte arriving this cycle) is presented combinationally.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        flush_last,
    output logic        word_complete,
    output logic [31:0] word
);

    logic [31:0] partial_word;
    logic [1:0]  byte_index;

    // Bytes land at their final lane so a flushed partial word keeps zero upper bytes.
    always_comb begin
        word = partial_word;
        word[8*byte_index +: 8] = byte_data;
        word_complete = byte_valid && ((byte_index == 2'd3) || flush_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            partial_word <= '0;
            byte_index   <= '0;
        end else if (clear) begin
            partial_word <= '0;
            byte_index   <= '0;
        end else if (byte_valid) begin
            if (word_complete) begin
                partial_word <= '0;
                byte_index   <= '0;
            end else begin
                partial_word <= word;
                byte_index   <= byte_index + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time UART program download: 0x99 greeting, 32-bit byte count, word writes, 0xAA.
// load_done follows the DONE state so it drops together with an asynchronous reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_ADDRESS_BITWIDTH = DEFAULT_PROGRAM_MEMORY_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    program_loader_if.master  bus,
    output logic              load_done,
    output logic              overflow
);

    localparam int AW = PROGRAM_MEMORY_ADDRESS_BITWIDTH;

    program_loader_state_t state, state_next;

    logic [31:0]   remaining;
    logic [AW-1:0] addr;
    logic          memory_full;

    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [31:0]   write_data;

    logic          asm_valid;
    logic          asm_flush;
    logic          asm_clear;
    logic          asm_complete;
    logic [31:0]   asm_word;
    logic          data_word_done;

    byte_word_assembler u_assembler (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (asm_clear),
        .byte_valid    (asm_valid),
        .byte_data     (bus.rx_data),
        .flush_last    (asm_flush),
        .word_complete (asm_complete),
        .word          (asm_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEND_99;
        end else begin
            state <= state_next;
        end
    end

    // Data bytes are only accepted while count remains; the zero-count cycle is the write cycle.
    always_comb begin
        state_next     = state;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        load_done      = 1'b0;
        asm_valid      = 1'b0;
        asm_flush      = 1'b0;
        asm_clear      = 1'b0;
        data_word_done = 1'b0;
        case (state)
            SEND_99: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = BOOT_START_BYTE;
                asm_clear    = 1'b1;
                if (bus.tx_ready) state_next = RECV_SIZE;
            end
            RECV_SIZE: begin
                asm_valid = bus.rx_valid;
                if (asm_complete) state_next = (asm_word == 32'd0) ? SEND_AA : RECV_DATA;
            end
            RECV_DATA: begin
                asm_valid      = bus.rx_valid && (remaining != 32'd0);
                asm_flush      = (remaining == 32'd1);
                data_word_done = asm_complete;
                if (remaining == 32'd0) state_next = SEND_AA;
            end
            SEND_AA: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = BOOT_END_BYTE;
                if (bus.tx_ready) state_next = DONE;
            end
            DONE: begin
                load_done = 1'b1;
            end
            default: state_next = SEND_99;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
        end else if (state == RECV_SIZE && asm_complete) begin
            remaining <= asm_word;
        end else if (state == RECV_DATA && asm_valid) begin
            remaining <= remaining - 32'd1;
        end
    end

    // Once the last address is written, further words are consumed but only raise overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            addr          <= '0;
            memory_full   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (data_word_done) begin
                if (!memory_full) begin
                    write_enable  <= 1'b1;
                    write_address <= addr;
                    write_data    <= asm_word;
                    if (addr == {AW{1'b1}}) begin
                        memory_full <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.program_memory_write_enable  = write_enable;
    assign bus.program_memory_write_address = write_address;
    assign bus.program_memory_write_data    = write_data;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader with a 4-word program memory so overflow is reachable.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int AW = 2;

    typedef struct {
        logic [31:0]  size;
        logic [159:0] data;
        int           nwrites;
        logic [127:0] words;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic load_done;
    logic overflow;

    int checks = 0;
    int failures = 0;

    vec_t vecs[6];

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    tx_q[$];

    always #5 clk = ~clk;

    program_loader_if #(.ADDRESS_BITWIDTH(AW)) bus ();

    program_loader #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .load_done (load_done),
        .overflow  (overflow)
    );

    // Records memory writes and completed transmit handshakes mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.program_memory_write_enable) begin
                wr_addr_q.push_back(bus.program_memory_write_address);
                wr_data_q.push_back(bus.program_memory_write_data);
            end
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic setVec(input int i, input logic [31:0] size, input logic [159:0] data,
                          input int nwrites, input logic [127:0] words, input logic ovf);
        vecs[i].size    = size;
        vecs[i].data    = data;
        vecs[i].nwrites = nwrites;
        vecs[i].words   = words;
        vecs[i].ovf     = ovf;
    endtask

    task automatic doReset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_tx", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, BOOT_START_BYTE});
        checkOutput("rst_we", 32'(bus.program_memory_write_enable), 32'd0);
        checkOutput("rst_addr", 32'(bus.program_memory_write_address), 32'd0);
        checkOutput("rst_data", bus.program_memory_write_data, 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic handshake99();
        checkOutput("greet_tx", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, BOOT_START_BYTE});
        bus.tx_ready = 1'b1;
        tick();
    endtask

    task automatic runVector(input int i);
        int n;
        int waited;
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = vecs[i].size[8*k +: 8];
            applyStimulus(b);
        end
        if (vecs[i].size == 32'd0) begin
            checkOutput($sformatf("v%0d_zero_aa_now", i), {23'd0, bus.tx_valid, bus.tx_data},
                        {23'd0, 1'b1, BOOT_END_BYTE});
        end else begin
            for (int k = 0; k < int'(vecs[i].size); k++) begin
                if (k == 16) checkOutput($sformatf("v%0d_ovf_early", i), 32'(overflow), 32'd0);
                b = vecs[i].data[8*k +: 8];
                applyStimulus(b);
            end
            checkOutput($sformatf("v%0d_last_we", i), 32'(bus.program_memory_write_enable), 32'(!vecs[i].ovf));
            checkOutput($sformatf("v%0d_last_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d_aa_not_yet", i), 32'(bus.tx_valid), 32'd0);
            tick();
            checkOutput($sformatf("v%0d_aa_rise", i), {23'd0, bus.tx_valid, bus.tx_data},
                        {23'd0, 1'b1, BOOT_END_BYTE});
        end
        waited = 0;
        while (!load_done && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput($sformatf("v%0d_load_done", i), 32'(load_done), 32'd1);
        checkOutput($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        applyStimulus(8'h55);
        tick();
        checkOutput($sformatf("v%0d_done_hold", i), 32'(load_done), 32'd1);
        n = wr_data_q.size();
        checkOutput($sformatf("v%0d_nwrites", i), n, vecs[i].nwrites);
        for (int j = 0; j < vecs[i].nwrites && j < n; j++) begin
            checkOutput($sformatf("v%0d_addr%0d", i, j), 32'(wr_addr_q[j]), j);
            checkOutput($sformatf("v%0d_word%0d", i, j), wr_data_q[j], vecs[i].words[32*j +: 32]);
        end
        checkOutput($sformatf("v%0d_ntx", i), tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            checkOutput($sformatf("v%0d_tx0", i), 32'(tx_q[0]), 32'h99);
            checkOutput($sformatf("v%0d_tx1", i), 32'(tx_q[1]), 32'hAA);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;

        setVec(0, 32'd8, 160'h0807060504030201, 2, {32'h08070605, 32'h04030201}, 1'b0);
        setVec(1, 32'd5, 160'hEEDDCCBBAA, 2, {32'h000000EE, 32'hDDCCBBAA}, 1'b0);
        setVec(2, 32'd0, 160'h0, 0, 128'h0, 1'b0);
        setVec(3, 32'd20, 160'h23222120_1F1E1D1C_1B1A1918_17161514_13121110, 4,
               {32'h1F1E1D1C, 32'h1B1A1918, 32'h17161514, 32'h13121110}, 1'b1);
        setVec(4, 32'd1, 160'h5A, 1, {96'h0, 32'h0000005A}, 1'b0);
        setVec(5, 32'd2, 160'h8877, 1, {96'h0, 32'h00008877}, 1'b0);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d", i);
            doReset();
            handshake99();
            runVector(i);
        end

        $display("[TB] backpressure with stray input");
        doReset();
        for (int k = 0; k < 10; k++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(8'h40 + k);
            tick();
            checkOutput($sformatf("bp_hold%0d", k), {23'd0, bus.tx_valid, bus.tx_data},
                        {23'd0, 1'b1, BOOT_START_BYTE});
        end
        bus.rx_valid = 1'b0;
        handshake99();
        runVector(5);

        $display("[TB] reset mid-load");
        doReset();
        handshake99();
        for (int k = 0; k < 4; k++) applyStimulus(8'(k == 0 ? 8 : 0));
        applyStimulus(8'hF1);
        applyStimulus(8'hF2);
        applyStimulus(8'hF3);
        checkOutput("mid_no_write", wr_data_q.size(), 0);
        doReset();
        handshake99();
        runVector(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
